load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 50 +++++
 rtl/load_store_unit_align.sv | 57 +++++
 rtl/load_store_unit.sv | 173 +++++++++++++++++
 tb/tb_load_store_unit.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: instruction encodings, FSM states and size masks.
// Split (misaligned) access support is selected with the MISALIGNED_SPLIT_EN macro.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        INSTR_NONE  = 2'd0,
        LOAD        = 2'd1,
        STORE       = 2'd2,
        INSTR_OTHER = 2'd3
    } InstructionTypes;

    typedef enum logic [2:0] {
        LOAD_BYTE   = 3'd0,
        LOAD_HALF   = 3'd1,
        LOAD_WORD   = 3'd2,
        ULOAD_BYTE  = 3'd3,
        ULOAD_HALF  = 3'd4,
        STORE_BYTE  = 3'd5,
        STORE_HALF  = 3'd6,
        STORE_WORD  = 3'd7
    } InstructionSubTypes;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    function automatic logic [2:0] size_bytes(input InstructionSubTypes t);
        case (t)
            LOAD_BYTE, ULOAD_BYTE, STORE_BYTE: return 3'd1;
            LOAD_HALF, ULOAD_HALF, STORE_HALF: return 3'd2;
            default:                           return 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] size_mask(input InstructionSubTypes t);
        case (t)
            LOAD_BYTE, ULOAD_BYTE, STORE_BYTE: return MASK_BYTE;
            LOAD_HALF, ULOAD_HALF, STORE_HALF: return MASK_HALF;
            default:                           return MASK_WORD;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane steering for the load/store unit: byte enables, store data shifting,
// split detection and load assembly/extension. Used with or without MISALIGNED_SPLIT_EN.
module lsu_align
    import load_store_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            offset,
    input  InstructionSubTypes    sub_type,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] rdata0,
    input  logic [DATA_WIDTH-1:0] rdata1,
    output logic                  split,
    output logic [3:0]            byte_en0,
    output logic [3:0]            byte_en1,
    output logic [DATA_WIDTH-1:0] wdata0,
    output logic [DATA_WIDTH-1:0] wdata1,
    output logic [DATA_WIDTH-1:0] load_data
);

    logic [3:0]              mask;
    logic [2:0]              nbytes;
    logic [4:0]              bit_off;
    logic [7:0]              be_wide;
    logic [2*DATA_WIDTH-1:0] wd_wide;
    logic [DATA_WIDTH-1:0]   hi_part;
    logic [DATA_WIDTH-1:0]   word;

    assign mask    = size_mask(sub_type);
    assign nbytes  = size_bytes(sub_type);
    assign bit_off = {offset, 3'b000};
    assign split   = ({1'b0, offset} + nbytes) > 3'd4;

    // Shifting into a double-width vector yields both beats at once: the upper half
    // is exactly what spills into the next word.
    assign be_wide  = {4'b0000, mask} << offset;
    assign wd_wide  = {{DATA_WIDTH{1'b0}}, store_data} << bit_off;
    assign byte_en0 = be_wide[3:0];
    assign byte_en1 = be_wide[7:4];
    assign wdata0   = wd_wide[DATA_WIDTH-1:0];
    assign wdata1   = wd_wide[2*DATA_WIDTH-1:DATA_WIDTH];

    assign hi_part = split ? (rdata1 << (6'd32 - {1'b0, bit_off})) : {DATA_WIDTH{1'b0}};
    assign word    = (rdata0 >> bit_off) | hi_part;

    always_comb begin
        load_data = word;
        case (sub_type)
            LOAD_BYTE:  load_data = {{(DATA_WIDTH-8){word[7]}}, word[7:0]};
            LOAD_HALF:  load_data = {{(DATA_WIDTH-16){word[15]}}, word[15:0]};
            ULOAD_BYTE: load_data = {{(DATA_WIDTH-8){1'b0}}, word[7:0]};
            ULOAD_HALF: load_data = {{(DATA_WIDTH-16){1'b0}}, word[15:0]};
            default:    ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory op at a time and runs up to two memory beats.
// Define MISALIGNED_SPLIT_EN to split word-crossing accesses; otherwise they fault.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iReqValid,
    output logic                  oReqReady,
    input  InstructionTypes       iInstructionType,
    input  InstructionSubTypes    iMemoryInstructionType,
    input  logic [31:0]           iAddress,
    input  logic [DATA_WIDTH-1:0] iStoreData,
    output logic                  oRespValid,
    output logic [DATA_WIDTH-1:0] oLoadData,
    output logic                  oMisaligned,
    output logic                  oMemReq,
    input  logic                  iMemAck,
    output logic                  oMemWe,
    output logic [31:0]           oMemAddr,
    output logic [3:0]            oMemByteEn,
    output logic [DATA_WIDTH-1:0] oMemWData,
    input  logic [DATA_WIDTH-1:0] iMemRData,
    output lsu_state_t            oState
);

`ifdef MISALIGNED_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    // Handshake: a request transfers on a rising edge where iReqValid and oReqReady are
    // both high; oReqReady is high only in IDLE and RESP. Each memory beat transfers on
    // an edge where oMemReq and iMemAck are both high; outputs hold until then.

    lsu_state_t            state;
    InstructionTypes       op_q;
    InstructionSubTypes    sub_q;
    logic [1:0]            off_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic                  zero_beat_q;
    logic                  fault_q;

    logic                  accept_phase;
    logic                  handshake;
    logic                  is_mem_in;
    logic                  first_ack;
    logic                  last_ack;

    logic [1:0]            al_offset;
    InstructionSubTypes    al_sub;
    logic [DATA_WIDTH-1:0] al_data;
    logic [DATA_WIDTH-1:0] al_rdata0;
    logic                  al_split;
    logic [3:0]            al_be0;
    logic [3:0]            al_be1;
    logic [DATA_WIDTH-1:0] al_wdata0;
    logic [DATA_WIDTH-1:0] al_wdata1;
    logic [DATA_WIDTH-1:0] al_load;

    assign oState       = state;
    assign accept_phase = (state == IDLE) || (state == RESP);
    assign handshake    = iReqValid && oReqReady;
    assign is_mem_in    = (iInstructionType == LOAD) || (iInstructionType == STORE);

    // The aligner sees the incoming request while accepting and the latched op otherwise.
    assign al_offset = accept_phase ? iAddress[1:0] : off_q;
    assign al_sub    = accept_phase ? iMemoryInstructionType : sub_q;
    assign al_data   = accept_phase ? iStoreData : data_q;
    assign al_rdata0 = (state == BEAT1) ? rdata0_q : iMemRData;

    assign first_ack = (state == BEAT0) && !zero_beat_q && iMemAck && al_split && SPLIT_EN;
    assign last_ack  = iMemAck && (((state == BEAT0) && !zero_beat_q && !(al_split && SPLIT_EN))
                                   || (state == BEAT1));

    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .offset     (al_offset),
        .sub_type   (al_sub),
        .store_data (al_data),
        .rdata0     (al_rdata0),
        .rdata1     (iMemRData),
        .split      (al_split),
        .byte_en0   (al_be0),
        .byte_en1   (al_be1),
        .wdata0     (al_wdata0),
        .wdata1     (al_wdata1),
        .load_data  (al_load)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state       <= IDLE;
            oReqReady   <= 1'b1;
            oRespValid  <= 1'b0;
            oMisaligned <= 1'b0;
            oLoadData   <= '0;
            oMemReq     <= 1'b0;
            oMemWe      <= 1'b0;
            oMemAddr    <= '0;
            oMemByteEn  <= '0;
            oMemWData   <= '0;
            op_q        <= INSTR_NONE;
            sub_q       <= LOAD_BYTE;
            off_q       <= '0;
            data_q      <= '0;
            rdata0_q    <= '0;
            zero_beat_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            oRespValid <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    oMisaligned <= 1'b0;
                    if (handshake) begin
                        state      <= BEAT0;
                        oReqReady  <= 1'b0;
                        op_q       <= iInstructionType;
                        sub_q      <= iMemoryInstructionType;
                        off_q      <= iAddress[1:0];
                        data_q     <= iStoreData;
                        oMemAddr   <= {iAddress[31:2], 2'b00};
                        oMemByteEn <= al_be0;
                        oMemWData  <= al_wdata0;
                        if (is_mem_in && !(al_split && !SPLIT_EN)) begin
                            oMemReq     <= 1'b1;
                            oMemWe      <= (iInstructionType == STORE);
                            zero_beat_q <= 1'b0;
                            fault_q     <= 1'b0;
                        end else begin
                            // Non-memory ops and unsupported splits pass through with no beat.
                            oMemReq     <= 1'b0;
                            oMemWe      <= 1'b0;
                            zero_beat_q <= 1'b1;
                            fault_q     <= is_mem_in;
                        end
                    end else begin
                        state     <= IDLE;
                        oReqReady <= 1'b1;
                    end
                end
                BEAT0: begin
                    if (zero_beat_q) begin
                        state       <= RESP;
                        oRespValid  <= 1'b1;
                        oMisaligned <= fault_q;
                        oReqReady   <= 1'b1;
                    end else if (first_ack) begin
                        state      <= BEAT1;
                        oMemAddr   <= oMemAddr + 32'd4;
                        oMemByteEn <= al_be1;
                        oMemWData  <= al_wdata1;
                        rdata0_q   <= iMemRData;
                    end
                end
                default: ;
            endcase

            if (last_ack) begin
                state       <= RESP;
                oMemReq     <= 1'b0;
                oRespValid  <= 1'b1;
                oMisaligned <= 1'b0;
                oReqReady   <= 1'b1;
                if (op_q == LOAD) oLoadData <= al_load;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a memory responder checks each beat against an
// expected-beat queue, a monitor checks each response against an expected-response queue.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [7:0]  wait_cycles;   // 8'hFF: never acknowledge
    } beat_t;

    typedef struct packed {
        logic        mis;
        logic [31:0] ld;
        logic        chk_lat;
        logic        b2b;
    } resp_t;

    logic               iClk;
    logic               iRst;
    logic               iReqValid;
    logic               oReqReady;
    InstructionTypes    iInstructionType;
    InstructionSubTypes iMemoryInstructionType;
    logic [31:0]        iAddress;
    logic [31:0]        iStoreData;
    logic               oRespValid;
    logic [31:0]        oLoadData;
    logic               oMisaligned;
    logic               oMemReq;
    logic               iMemAck;
    logic               oMemWe;
    logic [31:0]        oMemAddr;
    logic [3:0]         oMemByteEn;
    logic [31:0]        oMemWData;
    logic [31:0]        iMemRData;
    lsu_state_t         oState;

    beat_t       beat_q[$];
    resp_t       resp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          last_ack_cyc = 0;
    logic        prev_valid = 1'b0;
    logic        b2b_pending = 1'b0;
    logic [31:0] exp_ld;

    load_store_unit #(.DATA_WIDTH(32)) dut (
        .iClk                   (iClk),
        .iRst                   (iRst),
        .iReqValid              (iReqValid),
        .oReqReady              (oReqReady),
        .iInstructionType       (iInstructionType),
        .iMemoryInstructionType (iMemoryInstructionType),
        .iAddress               (iAddress),
        .iStoreData             (iStoreData),
        .oRespValid             (oRespValid),
        .oLoadData              (oLoadData),
        .oMisaligned            (oMisaligned),
        .oMemReq                (oMemReq),
        .iMemAck                (iMemAck),
        .oMemWe                 (oMemWe),
        .oMemAddr               (oMemAddr),
        .oMemByteEn             (oMemByteEn),
        .oMemWData              (oMemWData),
        .iMemRData              (iMemRData),
        .oState                 (oState)
    );

    // Clock and reset
    initial iClk = 1'b0;
    always #5 iClk = ~iClk;
    always @(posedge iClk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    endtask

    // Driver tasks
    task automatic push_beat(input logic we, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input logic [7:0] wait_cycles);
        beat_t b;
        b.we = we; b.addr = addr; b.be = be; b.wdata = wdata; b.rdata = rdata;
        b.wait_cycles = wait_cycles;
        beat_q.push_back(b);
    endtask

    task automatic push_resp(input logic mis, input logic [31:0] ld, input logic chk_lat,
                             input logic b2b);
        resp_t r;
        r.mis = mis; r.ld = ld; r.chk_lat = chk_lat; r.b2b = b2b;
        resp_q.push_back(r);
    endtask

    task automatic issue(input InstructionTypes t, input InstructionSubTypes s,
                         input logic [31:0] addr, input logic [31:0] data);
        int guard;
        guard = 0;
        @(negedge iClk);
        iReqValid = 1'b1;
        iInstructionType = t;
        iMemoryInstructionType = s;
        iAddress = addr;
        iStoreData = data;
        while (!oReqReady && guard < 200) begin
            @(negedge iClk);
            guard++;
        end
        if (!oReqReady) check("req_ready_timeout", 32'(oReqReady), 32'd1);
        else begin
            @(posedge iClk);
            #1;
        end
        iReqValid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((beat_q.size() != 0 || resp_q.size() != 0) && guard < 500) begin
            @(negedge iClk);
            guard++;
        end
        if (guard >= 500) check("drain_timeout", 32'(beat_q.size() + resp_q.size()), 32'd0);
        repeat (2) @(negedge iClk);
    endtask

    // Memory responder: checks each presented beat, then acknowledges after its wait count
    initial begin
        beat_t b;
        int    g;
        iMemAck = 1'b0;
        iMemRData = 32'h0;
        forever begin
            @(negedge iClk);
            if (!iRst && oMemReq) begin
                if (beat_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_beat: got oMemReq=1 at addr 0x%08h, expected no request",
                             oMemAddr);
                    iMemAck = 1'b1;
                    @(posedge iClk);
                    #1;
                    iMemAck = 1'b0;
                end else begin
                    b = beat_q.pop_front();
                    check("beat_we", 32'(oMemWe), 32'(b.we));
                    check("beat_addr", oMemAddr, b.addr);
                    check("beat_be", 32'(oMemByteEn), 32'(b.be));
                    if (b.we) check("beat_wdata", oMemWData, b.wdata);
                    if (b.wait_cycles == 8'hFF) begin
                        g = 0;
                        while (oMemReq && g < 400) begin
                            @(negedge iClk);
                            g++;
                        end
                    end else begin
                        repeat (int'(b.wait_cycles)) @(negedge iClk);
                        check("beat_req_held", 32'(oMemReq), 32'd1);
                        check("beat_addr_stable", oMemAddr, b.addr);
                        check("beat_be_stable", 32'(oMemByteEn), 32'(b.be));
                        iMemAck = 1'b1;
                        iMemRData = b.rdata;
                        @(posedge iClk);
                        #1;
                        last_ack_cyc = cyc;
                        iMemAck = 1'b0;
                        iMemRData = 32'h0;
                    end
                end
            end
        end
    end

    // Scoreboard monitor
    initial begin
        resp_t r;
        forever begin
            @(negedge iClk);
            if (b2b_pending) begin
                b2b_pending = 1'b0;
                check("b2b_state", 32'(oState), 32'(BEAT0));
                check("b2b_mem_req", 32'(oMemReq), 32'd1);
            end
            if (!iRst && oRespValid) begin
                if (resp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_resp: got oRespValid=1, expected no response");
                end else begin
                    r = resp_q.pop_front();
                    check("resp_misaligned", 32'(oMisaligned), 32'(r.mis));
                    check("resp_load_data", oLoadData, r.ld);
                    check("resp_pulse", 32'(prev_valid), 32'd0);
                    if (r.chk_lat) check("resp_latency", 32'(cyc), 32'(last_ack_cyc));
                    if (!r.b2b) check("beats_drained", 32'(beat_q.size()), 32'd0);
                    if (r.b2b) b2b_pending = 1'b1;
                end
            end
            prev_valid = oRespValid;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion (%0d/%0d checks passed)",
                 n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // Directed vectors
    initial begin
        int g;
        iRst = 1'b1;
        iReqValid = 1'b0;
        iInstructionType = INSTR_NONE;
        iMemoryInstructionType = LOAD_WORD;
        iAddress = 32'h0;
        iStoreData = 32'h0;
        exp_ld = 32'h0;

        repeat (2) @(negedge iClk);
        check("rst_mem_req", 32'(oMemReq), 32'd0);
        check("rst_resp_valid", 32'(oRespValid), 32'd0);
        check("rst_misaligned", 32'(oMisaligned), 32'd0);
        check("rst_load_data", oLoadData, 32'h0);
        check("rst_mem_we", 32'(oMemWe), 32'd0);
        check("rst_byte_en", 32'(oMemByteEn), 32'd0);
        check("rst_mem_addr", oMemAddr, 32'h0);
        check("rst_wdata", oMemWData, 32'h0);
        iRst = 1'b0;
        @(negedge iClk);
        check("idle_ready", 32'(oReqReady), 32'd1);
        check("idle_state", 32'(oState), 32'(IDLE));

        push_beat(1'b1, 32'h0001_0000, 4'b1111, 32'hDEAD_BEEF, 32'h0, 8'd2);
        push_resp(1'b0, exp_ld, 1'b1, 1'b0);
        issue(STORE, STORE_WORD, 32'h0001_0000, 32'hDEAD_BEEF);
        drain();

        push_beat(1'b0, 32'h0001_0000, 4'b1000, 32'h0, 32'h80FF_FFFF, 8'd1);
        exp_ld = 32'hFFFF_FF80;
        push_resp(1'b0, exp_ld, 1'b1, 1'b0);
        issue(LOAD, LOAD_BYTE, 32'h0001_0003, 32'h0);
        drain();

        push_beat(1'b0, 32'h0001_0000, 4'b1000, 32'h0, 32'h80FF_FFFF, 8'd0);
        exp_ld = 32'h0000_0080;
        push_resp(1'b0, exp_ld, 1'b1, 1'b0);
        issue(LOAD, ULOAD_BYTE, 32'h0001_0003, 32'h0);
        drain();

        push_beat(1'b0, 32'h0001_0000, 4'b1100, 32'h0, 32'h8234_5678, 8'd3);
        exp_ld = 32'hFFFF_8234;
        push_resp(1'b0, exp_ld, 1'b1, 1'b0);
        issue(LOAD, LOAD_HALF, 32'h0001_0002, 32'h0);
        drain();

        push_beat(1'b0, 32'h0001_0000, 4'b0011, 32'h0, 32'h1234_F00D, 8'd1);
        exp_ld = 32'h0000_F00D;
        push_resp(1'b0, exp_ld, 1'b1, 1'b0);
        issue(LOAD, ULOAD_HALF, 32'h0001_0000, 32'h0);
        drain();

        push_beat(1'b1, 32'h0001_0000, 4'b0010, 32'h0000_AB00, 32'h0, 8'd0);
        push_resp(1'b0, exp_ld, 1'b1, 1'b0);
        issue(STORE, STORE_BYTE, 32'h0001_0001, 32'h0000_00AB);
        drain();

        push_beat(1'b1, 32'h0001_0000, 4'b1100, 32'hBEEF_0000, 32'h0, 8'd1);
        push_resp(1'b0, exp_ld, 1'b1, 1'b0);
        issue(STORE, STORE_HALF, 32'h0001_0002, 32'h0000_BEEF);
        drain();

        push_resp(1'b0, exp_ld, 1'b0, 1'b0);
        issue(INSTR_OTHER, LOAD_WORD, 32'h0001_0000, 32'h0);
        drain();
        push_resp(1'b0, exp_ld, 1'b0, 1'b0);
        issue(INSTR_NONE, STORE_WORD, 32'h0001_0000, 32'h1111_2222);
        drain();

`ifdef MISALIGNED_SPLIT_EN
        push_beat(1'b0, 32'h0001_0000, 4'b1100, 32'h0, 32'h3344_AAAA, 8'd1);
        push_beat(1'b0, 32'h0001_0004, 4'b0011, 32'h0, 32'hBBBB_1122, 8'd0);
        exp_ld = 32'h1122_3344;
        push_resp(1'b0, exp_ld, 1'b1, 1'b0);
        issue(LOAD, LOAD_WORD, 32'h0001_0002, 32'h0);
        drain();

        push_beat(1'b1, 32'h0001_0000, 4'b1000, 32'hEF00_0000, 32'h0, 8'd0);
        push_beat(1'b1, 32'h0001_0004, 4'b0001, 32'h0000_00BE, 32'h0, 8'd1);
        push_resp(1'b0, exp_ld, 1'b1, 1'b0);
        issue(STORE, STORE_HALF, 32'h0001_0003, 32'h0000_BEEF);
        drain();

        push_beat(1'b0, 32'hFFFF_FFFC, 4'b1000, 32'h0, 32'h4400_0000, 8'd0);
        push_beat(1'b0, 32'h0000_0000, 4'b0111, 32'h0, 32'h0011_2233, 8'd2);
        exp_ld = 32'h1122_3344;
        push_resp(1'b0, exp_ld, 1'b1, 1'b0);
        issue(LOAD, LOAD_WORD, 32'hFFFF_FFFF, 32'h0);
        drain();
`else
        push_resp(1'b1, exp_ld, 1'b0, 1'b0);
        issue(STORE, STORE_HALF, 32'h0001_0003, 32'h0000_BEEF);
        drain();

        push_resp(1'b1, exp_ld, 1'b0, 1'b0);
        issue(LOAD, LOAD_WORD, 32'h0001_0002, 32'h0);
        drain();
`endif

        push_beat(1'b1, 32'h0003_0000, 4'b1111, 32'hA5A5_0001, 32'h0, 8'd0);
        push_resp(1'b0, exp_ld, 1'b1, 1'b1);
        push_beat(1'b1, 32'h0003_0004, 4'b1111, 32'hA5A5_0002, 32'h0, 8'd1);
        push_resp(1'b0, exp_ld, 1'b1, 1'b0);
        issue(STORE, STORE_WORD, 32'h0003_0000, 32'hA5A5_0001);
        issue(STORE, STORE_WORD, 32'h0003_0004, 32'hA5A5_0002);
        drain();

        // Reset while a beat is waiting for an ack that never comes
`ifdef MISALIGNED_SPLIT_EN
        push_beat(1'b0, 32'h0002_0000, 4'b1100, 32'h0, 32'h1234_5678, 8'd0);
        push_beat(1'b0, 32'h0002_0004, 4'b0011, 32'h0, 32'h0, 8'hFF);
        issue(LOAD, LOAD_WORD, 32'h0002_0002, 32'h0);
        g = 0;
        while (oState != BEAT1 && g < 100) begin
            @(negedge iClk);
            g++;
        end
        check("reach_beat1", 32'(oState), 32'(BEAT1));
`else
        push_beat(1'b0, 32'h0002_0000, 4'b1111, 32'h0, 32'h0, 8'hFF);
        issue(LOAD, LOAD_WORD, 32'h0002_0000, 32'h0);
        g = 0;
        while (oState != BEAT0 && g < 100) begin
            @(negedge iClk);
            g++;
        end
        check("reach_beat0", 32'(oState), 32'(BEAT0));
`endif
        repeat (2) @(negedge iClk);
        #2;
        iRst = 1'b1;
        #1;
        check("rst_async_mem_req", 32'(oMemReq), 32'd0);
        check("rst_async_state", 32'(oState), 32'(IDLE));
        repeat (2) @(negedge iClk);
        iRst = 1'b0;
        exp_ld = 32'h0;
        @(negedge iClk);
        check("rst_release_ready", 32'(oReqReady), 32'd1);
        check("rst_no_resp", 32'(oRespValid), 32'd0);
        check("rst_no_pending", 32'(beat_q.size() + resp_q.size()), 32'd0);

        push_beat(1'b1, 32'h0002_0000, 4'b0001, 32'h0000_005A, 32'h0, 8'd1);
        push_resp(1'b0, exp_ld, 1'b1, 1'b0);
        issue(STORE, STORE_BYTE, 32'h0002_0000, 32'h0000_005A);
        drain();

        push_beat(1'b0, 32'h0002_0000, 4'b1100, 32'h0, 32'hABCD_0000, 8'd2);
        exp_ld = 32'h0000_ABCD;
        push_resp(1'b0, exp_ld, 1'b1, 1'b0);
        issue(LOAD, ULOAD_HALF, 32'h0002_0002, 32'h0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
